// File: rtl/snake_engine_if.sv
// snake_engine_if: control, status and segment read port of the engine.
// master = button/tick/render side, slave = engine.
interface snake_engine_if #(
    parameter int X_W     = 4,
    parameter int Y_W     = 4,
    parameter int MAX_LEN = 32
);
    localparam int IW = $clog2(MAX_LEN);

    logic           restart;
    logic           step;
    logic           btnUp;
    logic           btnDown;
    logic           btnLeft;
    logic           btnRight;
    logic [X_W-1:0] foodX;
    logic [Y_W-1:0] foodY;
    logic [IW-1:0]  seg_idx;
    logic [X_W-1:0] seg_x;
    logic [Y_W-1:0] seg_y;
    logic           seg_valid;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [IW:0]    length;
    logic           alive;
    logic           ate;
    logic           busy;

    modport master (
        output restart, step,
        output btnUp, btnDown, btnLeft, btnRight,
        output foodX, foodY, seg_idx,
        input  seg_x, seg_y, seg_valid,
        input  head_x, head_y, length,
        input  alive, ate, busy
    );

    modport slave (
        input  restart, step,
        input  btnUp, btnDown, btnLeft, btnRight,
        input  foodX, foodY, seg_idx,
        output seg_x, seg_y, seg_valid,
        output head_x, head_y, length,
        output alive, ate, busy
    );
endinterface

// File: rtl/snake_engine.sv
// snake_engine: snake state, ring-buffer body and move sequencing.
// A move runs CALC -> SCAN (self-collision) -> COMMIT, one segment per cycle.
module snake_engine #(
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 8,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 4,
    parameter int START_Y  = 3,
    parameter int WRAP     = 1
) (
    input logic clk,
    input logic reset,
    snake_engine_if.slave bus
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    typedef logic [X_W+Y_W-1:0] cellT;

    typedef enum logic [2:0] {
        INIT, IDLE, CALC, SCAN, COMMIT, DEAD
    } stateT;

    typedef enum logic [1:0] {
        UP, DOWN, LEFT, RIGHT
    } dirT;

    stateT state, stateNext;
    cellT mem [MAX_LEN];

    logic [IW-1:0]  headPtr, initCnt, scanIdx;
    logic [IW-1:0]  wrPtr, rdPtr;
    logic [LW-1:0]  len, scanN;
    logic [X_W-1:0] headX, nextX, segX;
    logic [Y_W-1:0] headY, nextY, segY;
    cellT           nextCell, scanCell;
    logic           grow, ateR, alive, segValid;
    logic           wallHit, hitFood, busy;
    logic           initLast, lastScan, scanHit;
    logic           reqValid;
    dirT            curDir, pendDir, moveDir;
    dirT            refDir, reqDir;

    assign wrPtr    = headPtr - IW'(1);
    assign rdPtr    = headPtr + bus.seg_idx;
    assign scanCell = mem[headPtr + scanIdx];
    assign scanHit  = scanCell == nextCell;
    assign lastScan = (LW'(scanIdx) + LW'(1)) >= scanN;
    assign initLast = initCnt == IW'(INIT_LEN - 1);
    assign hitFood  = {nextX, nextY} == {bus.foodX, bus.foodY};

    // While a move is in flight, legality is judged against the move's dir
    assign refDir = (state == SCAN || state == COMMIT) ? moveDir : curDir;

    // Highest-priority button that does not reverse the snake
    always_comb begin
        reqValid = 1'b0;
        reqDir   = pendDir;
        if (bus.btnUp && refDir != DOWN) begin
            reqValid = 1'b1;
            reqDir   = UP;
        end else if (bus.btnDown && refDir != UP) begin
            reqValid = 1'b1;
            reqDir   = DOWN;
        end else if (bus.btnLeft && refDir != RIGHT) begin
            reqValid = 1'b1;
            reqDir   = LEFT;
        end else if (bus.btnRight && refDir != LEFT) begin
            reqValid = 1'b1;
            reqDir   = RIGHT;
        end
    end

    // Candidate head one cell along the pending dir, with edge wrap
    always_comb begin
        nextX   = headX;
        nextY   = headY;
        wallHit = 1'b0;
        unique case (pendDir)
            UP: begin
                if (headY == '0) begin
                    nextY   = Y_W'(GRID_H - 1);
                    wallHit = 1'b1;
                end else begin
                    nextY = headY - Y_W'(1);
                end
            end
            DOWN: begin
                if (headY == Y_W'(GRID_H - 1)) begin
                    nextY   = '0;
                    wallHit = 1'b1;
                end else begin
                    nextY = headY + Y_W'(1);
                end
            end
            LEFT: begin
                if (headX == '0) begin
                    nextX   = X_W'(GRID_W - 1);
                    wallHit = 1'b1;
                end else begin
                    nextX = headX - X_W'(1);
                end
            end
            default: begin
                if (headX == X_W'(GRID_W - 1)) begin
                    nextX   = '0;
                    wallHit = 1'b1;
                end else begin
                    nextX = headX + X_W'(1);
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= stateNext;
    end

    // Next state and busy; restart overrides everything
    always_comb begin
        stateNext = state;
        busy      = state != IDLE;
        if (bus.restart) begin
            stateNext = INIT;
        end else begin
            unique case (state)
                INIT:   if (initLast) stateNext = IDLE;
                IDLE:   if (bus.step) stateNext = CALC;
                CALC: begin
                    if (wallHit && WRAP == 0) stateNext = DEAD;
                    else                      stateNext = SCAN;
                end
                SCAN: begin
                    if (scanHit)       stateNext = DEAD;
                    else if (lastScan) stateNext = COMMIT;
                end
                COMMIT: stateNext = IDLE;
                default: stateNext = state;
            endcase
        end
    end

    // Game state: head, length, direction, scan bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            initCnt  <= '0;
            headPtr  <= '0;
            headX    <= X_W'(START_X);
            headY    <= Y_W'(START_Y);
            len      <= '0;
            alive    <= 1'b1;
            ateR     <= 1'b0;
            curDir   <= RIGHT;
            pendDir  <= RIGHT;
            moveDir  <= RIGHT;
            scanIdx  <= '0;
            scanN    <= '0;
            nextCell <= '0;
            grow     <= 1'b0;
        end else if (bus.restart) begin
            initCnt <= '0;
            headPtr <= '0;
            headX   <= X_W'(START_X);
            headY   <= Y_W'(START_Y);
            len     <= '0;
            alive   <= 1'b1;
            ateR    <= 1'b0;
            curDir  <= RIGHT;
            pendDir <= RIGHT;
        end else begin
            ateR <= 1'b0;
            if (state != DEAD && reqValid) pendDir <= reqDir;
            unique case (state)
                INIT: begin
                    headPtr <= '0;
                    initCnt <= initLast ? '0 : initCnt + IW'(1);
                    if (initLast) len <= LW'(INIT_LEN);
                end
                CALC: begin
                    nextCell <= {nextX, nextY};
                    grow     <= hitFood;
                    scanN    <= hitFood ? len : len - LW'(1);
                    scanIdx  <= '0;
                    moveDir  <= pendDir;
                    if (wallHit && WRAP == 0) alive <= 1'b0;
                end
                SCAN: begin
                    scanIdx <= scanIdx + IW'(1);
                    if (scanHit) alive <= 1'b0;
                end
                COMMIT: begin
                    headPtr        <= wrPtr;
                    {headX, headY} <= nextCell;
                    curDir         <= moveDir;
                    ateR           <= grow;
                    if (grow && len < LW'(MAX_LEN)) len <= len + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Body buffer writes: initial body, then each committed head
    always_ff @(posedge clk) begin
        if (!bus.restart) begin
            if (state == INIT)
                mem[initCnt] <= {X_W'(START_X) - X_W'(initCnt),
                                 Y_W'(START_Y)};
            else if (state == COMMIT)
                mem[wrPtr] <= nextCell;
        end
    end

    // Registered segment read; sees the buffer before same-edge writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segX     <= '0;
            segY     <= '0;
            segValid <= 1'b0;
        end else begin
            {segX, segY} <= mem[rdPtr];
            segValid     <= LW'(bus.seg_idx) < len;
        end
    end

    assign bus.seg_x     = segX;
    assign bus.seg_y     = segY;
    assign bus.seg_valid = segValid;
    assign bus.head_x    = headX;
    assign bus.head_y    = headY;
    assign bus.length    = len;
    assign bus.alive     = alive;
    assign bus.ate       = ateR;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: random and directed moves against a queue-based snake
// model; a monitor compares each finished move or death with the model.
module tb_snake_engine;
    localparam int X_W = 4;
    localparam int Y_W = 4;
    localparam int GW  = 16;
    localparam int GH  = 8;
    localparam int ML  = 32;
    localparam int IL  = 3;
    localparam int SX  = 4;
    localparam int SY  = 3;
    localparam int IW  = $clog2(ML);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    snake_engine_if #(.X_W(X_W), .Y_W(Y_W), .MAX_LEN(ML)) bus ();
    snake_engine_if #(.X_W(X_W), .Y_W(Y_W), .MAX_LEN(ML)) bus0 ();

    snake_engine #(
        .X_W(X_W), .Y_W(Y_W), .GRID_W(GW), .GRID_H(GH),
        .MAX_LEN(ML), .INIT_LEN(IL), .START_X(SX), .START_Y(SY),
        .WRAP(1)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    snake_engine #(
        .X_W(X_W), .Y_W(Y_W), .GRID_W(GW), .GRID_H(GH),
        .MAX_LEN(ML), .INIT_LEN(IL), .START_X(SX), .START_Y(SY),
        .WRAP(0)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 init done, 1 move done, 2 death
    typedef struct {
        int kind;
        int hx;
        int hy;
        int len;
        int ate;
        int lat;
        int issue;
    } expT;

    expT  q[$];
    expT  e;
    int   bx[$];
    int   by[$];
    int   mDir;
    int   mPend;
    bit   mAlive;
    bit   monOn  = 1'b0;
    logic pBusy  = 1'b1;
    logic pAlive = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: a move/init ends when busy drops, a death when alive drops
    always @(negedge clk) begin
        if (monOn && ((pBusy && !bus.busy && bus.alive) ||
                      (pAlive && !bus.alive))) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious event: got busy=%0d alive=%0d required none",
                         bus.busy, bus.alive);
            end else begin
                e = q.pop_front();
                chk("alive", int'(bus.alive), int'(e.kind != 2));
                chk("head_x", int'(bus.head_x), e.hx);
                chk("head_y", int'(bus.head_y), e.hy);
                chk("length", int'(bus.length), e.len);
                chk("ate", int'(bus.ate), e.ate);
                if (e.lat > 0) chk("latency", cyc - e.issue, e.lat);
            end
        end
        pBusy  <= bus.busy;
        pAlive <= bus.alive;
    end

    function automatic void modelInit();
        bx.delete();
        by.delete();
        for (int i = 0; i < IL; i++) begin
            bx.push_back(SX - i);
            by.push_back(SY);
        end
        mDir   = 3;
        mPend  = 3;
        mAlive = 1'b1;
    endfunction

    task automatic waitDone(input string tag);
        int n = 0;
        while (bus.busy && bus.alive && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got busy=%0d required 0", tag, bus.busy);
        end
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right; held for one cycle
    task automatic press(input int mask);
        if (mask != 0) begin
            bus.btnUp    = mask[0];
            bus.btnDown  = mask[1];
            bus.btnLeft  = mask[2];
            bus.btnRight = mask[3];
            for (int d = 0; d < 4; d++) begin
                if (mask[d] && d != (mDir ^ 1)) begin
                    mPend = d;
                    break;
                end
            end
            @(negedge clk);
            bus.btnUp    = 1'b0;
            bus.btnDown  = 1'b0;
            bus.btnLeft  = 1'b0;
            bus.btnRight = 1'b0;
        end
    endtask

    // feed: 0 food elsewhere, 1 food on next head, 2 random food
    task automatic doStep(input int mask, input int feed, input bit extra);
        int nx, ny, fx, fy, n, k, issue;
        bit grow;
        press(mask);
        nx = bx[0];
        ny = by[0];
        case (mPend)
            0:       ny = ny - 1;
            1:       ny = ny + 1;
            2:       nx = nx - 1;
            default: nx = nx + 1;
        endcase
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        if (feed == 1) begin
            fx = nx;
            fy = ny;
        end else if (feed == 0) begin
            fx = (nx + GW / 2) % GW;
            fy = ny;
        end else begin
            fx = $urandom_range(GW - 1);
            fy = $urandom_range(GH - 1);
        end
        grow = (fx == nx) && (fy == ny);
        n = grow ? bx.size() : bx.size() - 1;
        k = -1;
        for (int i = 0; i < n; i++)
            if (k < 0 && bx[i] == nx && by[i] == ny) k = i;
        issue = cyc;
        if (k >= 0) begin
            q.push_back('{2, bx[0], by[0], bx.size(), 0, k + 3, issue});
            mAlive = 1'b0;
        end else begin
            bx.push_front(nx);
            by.push_front(ny);
            if (!grow || bx.size() > ML) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            mDir = mPend;
            q.push_back('{1, nx, ny, bx.size(), int'(grow), n + 3, issue});
        end
        bus.foodX = X_W'(fx);
        bus.foodY = Y_W'(fy);
        bus.step  = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        if (extra) begin
            bus.step = 1'b1;
            @(negedge clk);
            bus.step = 1'b0;
        end
        waitDone("step");
    endtask

    task automatic doRestart();
        q.push_back('{0, SX, SY, IL, 0, IL + 1, cyc});
        modelInit();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        waitDone("restart");
    endtask

    task automatic sweep();
        for (int i = 0; i < ML; i++) begin
            bus.seg_idx = IW'(i);
            @(negedge clk);
            chk($sformatf("seg_valid[%0d]", i), int'(bus.seg_valid),
                int'(i < bx.size()));
            if (i < bx.size()) begin
                chk($sformatf("seg_x[%0d]", i), int'(bus.seg_x), bx[i]);
                chk($sformatf("seg_y[%0d]", i), int'(bus.seg_y), by[i]);
            end
        end
    endtask

    task automatic step0();
        int n = 0;
        bus0.step = 1'b1;
        @(negedge clk);
        bus0.step = 1'b0;
        while (bus0.busy && bus0.alive && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL wall step timeout: got busy=%0d required 0", bus0.busy);
        end
    endtask

    function automatic int fillMask(input int s);
        if (s < 11)  return 8;
        if (s == 11) return 2;
        if (s < 27)  return 4;
        if (s == 27) return 2;
        return 8;
    endfunction

    initial begin
        int mask, feed, n;
        bus.restart  = 1'b0;
        bus.step     = 1'b0;
        bus.btnUp    = 1'b0;
        bus.btnDown  = 1'b0;
        bus.btnLeft  = 1'b0;
        bus.btnRight = 1'b0;
        bus.foodX    = '0;
        bus.foodY    = '0;
        bus.seg_idx  = '0;
        bus0.restart  = 1'b0;
        bus0.step     = 1'b0;
        bus0.btnUp    = 1'b0;
        bus0.btnDown  = 1'b0;
        bus0.btnLeft  = 1'b0;
        bus0.btnRight = 1'b0;
        bus0.foodX    = '0;
        bus0.foodY    = '0;
        bus0.seg_idx  = '0;
        modelInit();
        monOn = 1'b1;
        repeat (3) @(negedge clk);
        q.push_back('{0, SX, SY, IL, 0, IL, cyc});
        reset = 1'b1;
        waitDone("init");
        sweep();

        // Wall-death variant
        chk("wall length", int'(bus0.length), IL);
        for (int i = 0; i < 11; i++) step0();
        chk("wall head_x edge", int'(bus0.head_x), GW - 1);
        step0();
        chk("wall alive", int'(bus0.alive), 0);
        chk("wall head_x frozen", int'(bus0.head_x), GW - 1);
        step0();
        repeat (3) @(negedge clk);
        chk("wall dead alive", int'(bus0.alive), 0);
        chk("wall dead head_x", int'(bus0.head_x), GW - 1);
        chk("wall dead busy", int'(bus0.busy), 1);
        chk("wall dead length", int'(bus0.length), IL);
        bus0.restart = 1'b1;
        @(negedge clk);
        bus0.restart = 1'b0;
        chk("wall restart alive", int'(bus0.alive), 1);
        chk("wall restart length", int'(bus0.length), 0);
        n = 0;
        while (bus0.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wall reinit length", int'(bus0.length), IL);
        chk("wall reinit head_x", int'(bus0.head_x), SX);
        chk("wall reinit head_y", int'(bus0.head_y), SY);

        // Reversal ignored, eat, tail-chasing loop, then self-hit
        doStep(4, 0, 1'b0);
        doStep(0, 1, 1'b0);
        repeat (2) begin
            doStep(2, 0, 1'b1);
            doStep(4, 0, 1'b0);
            doStep(1, 0, 1'b0);
            doStep(8, 0, 1'b1);
        end
        doStep(8, 1, 1'b0);
        doStep(2, 0, 1'b0);
        doStep(4, 0, 1'b0);
        doStep(1, 0, 1'b0);
        doRestart();

        // Right-edge wrap
        for (int i = 0; i < 12; i++) doStep(8, 0, 1'b0);
        sweep();

        // Random play
        for (int r = 0; r < 150; r++) begin
            if (!mAlive) begin
                doRestart();
            end else begin
                mask = ($urandom_range(1) == 1) ? $urandom_range(15) : 0;
                feed = ($urandom_range(2) == 0) ? 1 : 2;
                doStep(mask, feed, $urandom_range(3) == 0);
            end
            if (r % 50 == 49 && mAlive) sweep();
        end

        // Serpentine growth to full buffer, then saturated eating
        doRestart();
        for (int s = 0; s < 34; s++) doStep(fillMask(s), 1, s[0]);
        sweep();
        chk("queue drained", q.size(), 0);

        // Async reset in the middle of a scan
        monOn = 1'b0;
        q.delete();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst head_x", int'(bus.head_x), SX);
        chk("rst head_y", int'(bus.head_y), SY);
        chk("rst length", int'(bus.length), 0);
        chk("rst alive", int'(bus.alive), 1);
        chk("rst ate", int'(bus.ate), 0);
        chk("rst busy", int'(bus.busy), 1);
        chk("rst seg_valid", int'(bus.seg_valid), 0);
        chk("rst seg_x", int'(bus.seg_x), 0);
        chk("rst seg_y", int'(bus.seg_y), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
